// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the ADV7513 init/read masters and the register target.
// Keeps bus constants and target state encoding in one place.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    localparam logic [6:0] ADV7513_ADDR_7B = 7'h39;
    localparam logic       ACK_BIT         = 1'b0;
    localparam logic       NACK_BIT        = 1'b1;
    localparam int         I2C_CLKDIV      = 250;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for raw SCL/SDA plus edge, START and STOP detection.
// Registers reset to 1 so an idle bus produces no spurious edges.
module i2c_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [2:0] scl_q;
    logic [2:0] sda_q;
    logic       sda_rise;
    logic       sda_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl_in};
            sda_q <= {sda_q[1:0], sda_in};
        end
    end

    assign sda       = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign sda_rise  = sda_q[1] & ~sda_q[2];
    assign sda_fall  = ~sda_q[1] & sda_q[2];
    assign start_det = sda_fall & scl_q[1];
    assign stop_det  = sda_rise & scl_q[1];

endmodule

// File: rtl/i2c_reg_target.sv
// I2C register-file target emulating the ADV7513 register interface.
// Pointer byte then data bytes on write; reads stream from the current pointer.
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = ADV7513_ADDR_7B,
    parameter int         REG_AW   = 8,
    parameter int         SDA_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              wr_strobe,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [REG_AW-1:0] host_addr,
    output logic [7:0]        host_data,
    output logic              busy
);

    localparam int HW = $clog2(SDA_HOLD + 1);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_sync_edge u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    logic [7:0]        regfile [2**REG_AW];
    state_t            state;
    logic [7:0]        sh;
    logic [3:0]        cnt;
    logic [REG_AW-1:0] ptr;
    logic              rw;
    logic              ack_rx;
    logic              oe_pend;
    logic [HW-1:0]     hold;
    logic              addr_hit;

    assign addr_hit = (sh[7:1] == DEV_ADDR);

    // Each SCL fall arms the hold timer; oe_pend is what SDA becomes when it expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            ptr       <= '0;
            sh        <= '0;
            cnt       <= '0;
            rw        <= 1'b0;
            ack_rx    <= NACK_BIT;
            oe_pend   <= 1'b0;
            hold      <= '0;
        end else if (start_det) begin
            wr_strobe <= 1'b0;
            state     <= ST_ADDR;
            cnt       <= '0;
            sda_oe    <= 1'b0;
            hold      <= '0;
        end else if (stop_det) begin
            wr_strobe <= 1'b0;
            state     <= ST_IDLE;
            sda_oe    <= 1'b0;
            hold      <= '0;
            busy      <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (hold != '0) begin
                hold <= hold - HW'(1);
                if (hold == HW'(1))
                    sda_oe <= oe_pend;
            end
            if (scl_rise) begin
                case (state)
                    ST_ADDR, ST_REG, ST_WDATA: begin
                        sh  <= {sh[6:0], sda_s};
                        cnt <= cnt + 4'd1;
                    end
                    ST_RDATA:     cnt    <= cnt + 4'd1;
                    ST_RDATA_ACK: ack_rx <= sda_s;
                    default: ;
                endcase
            end
            if (scl_fall) begin
                hold    <= HW'(SDA_HOLD);
                oe_pend <= 1'b0;
                case (state)
                    ST_ADDR: if (cnt == 4'd8) begin
                        cnt <= '0;
                        if (addr_hit) begin
                            state   <= ST_ADDR_ACK;
                            rw      <= sh[0];
                            busy    <= 1'b1;
                            oe_pend <= ~ACK_BIT;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                    ST_REG: if (cnt == 4'd8) begin
                        cnt     <= '0;
                        ptr     <= REG_AW'(sh);
                        state   <= ST_REG_ACK;
                        oe_pend <= ~ACK_BIT;
                    end
                    ST_WDATA: if (cnt == 4'd8) begin
                        cnt       <= '0;
                        wr_strobe <= 1'b1;
                        wr_addr   <= ptr;
                        wr_data   <= sh;
                        ptr       <= ptr + REG_AW'(1);
                        state     <= ST_WDATA_ACK;
                        oe_pend   <= ~ACK_BIT;
                    end
                    ST_ADDR_ACK: begin
                        cnt <= '0;
                        if (rw) begin
                            state   <= ST_RDATA;
                            sh      <= regfile[ptr];
                            oe_pend <= ~regfile[ptr][7];
                        end else begin
                            state <= ST_REG;
                        end
                    end
                    ST_REG_ACK, ST_WDATA_ACK: begin
                        cnt   <= '0;
                        state <= ST_WDATA;
                    end
                    ST_RDATA: if (cnt == 4'd8) begin
                        cnt   <= '0;
                        ptr   <= ptr + REG_AW'(1);
                        state <= ST_RDATA_ACK;
                    end else begin
                        sh      <= {sh[6:0], 1'b0};
                        oe_pend <= ~sh[6];
                    end
                    ST_RDATA_ACK: begin
                        cnt <= '0;
                        if (ack_rx == ACK_BIT) begin
                            state   <= ST_RDATA;
                            sh      <= regfile[ptr];
                            oe_pend <= ~regfile[ptr][7];
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Written from the registered strobe so the file stays a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_strobe)
            regfile[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            host_data <= '0;
        else
            host_data <= regfile[host_addr];
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: bit-banged I2C master on a wired-AND SDA.
module tb_i2c_reg_target;

    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] host_addr;
    logic [7:0] host_data;
    logic       busy;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] sa[$];
    logic [7:0] sd[$];
    logic       oe_seen = 1'b0;

    assign sda_bus = sda_m & ~sda_oe;

    always #10 clk = ~clk;

    i2c_reg_target dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .host_addr (host_addr),
        .host_data (host_data),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            sa.push_back(wr_addr);
            sd.push_back(wr_data);
        end
        if (sda_oe === 1'b1)
            oe_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq(Q);
        scl   = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl   = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq(Q);
        scl   = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
    endtask

    task automatic clk_bit(input logic b, output logic r);
        sda_m = b;    wq(Q);
        scl   = 1'b1; wq(Q);
        r     = sda_bus;
        wq(Q);
        scl   = 1'b0; wq(Q);
    endtask

    task automatic send(input logic [7:0] b, input logic exp_ack,
                        input string tag);
        logic r;
        for (int i = 7; i >= 0; i--)
            clk_bit(b[i], r);
        clk_bit(1'b1, r);
        chk(tag, r, exp_ack);
    endtask

    task automatic recv(input logic nack, input logic [7:0] exp,
                        input string tag);
        logic       r;
        logic [7:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, r);
            d = {d[6:0], r};
        end
        clk_bit(nack, r);
        chk(tag, d, exp);
    endtask

    task automatic hread(input logic [7:0] a, input logic [7:0] exp,
                         input string tag);
        host_addr = a;
        @(posedge clk); #1;
        chk(tag, host_data, exp);
    endtask

    initial begin
        logic r;
        reset = 1'b1; scl = 1'b1; sda_m = 1'b1; host_addr = '0;
        wq(5);
        chk("rst_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_hdata", host_data, 0);
        reset = 1'b0;
        wq(5);

        // single write 0x41 = 0x10
        sa.delete(); sd.delete();
        i2c_start();
        send(8'h72, 1'b0, "sw_ack_dev");
        send(8'h41, 1'b0, "sw_ack_reg");
        send(8'h10, 1'b0, "sw_ack_dat");
        chk("sw_busy", busy, 1);
        i2c_stop();
        chk("sw_busy_off", busy, 0);
        chk("sw_nstb", sa.size(), 1);
        chk("sw_waddr", sa[0], 8'h41);
        chk("sw_wdata", sd[0], 8'h10);
        hread(8'h41, 8'h10, "sw_host");

        // seed 0x9B so the burst's final ptr is observable
        i2c_start();
        send(8'h72, 1'b0, "s9b_dev");
        send(8'h9B, 1'b0, "s9b_reg");
        send(8'h5A, 1'b0, "s9b_dat");
        i2c_stop();

        // burst write 0x98..0x9A
        sa.delete(); sd.delete();
        i2c_start();
        send(8'h72, 1'b0, "bw_dev");
        send(8'h98, 1'b0, "bw_reg");
        send(8'h03, 1'b0, "bw_d0");
        send(8'h02, 1'b0, "bw_d1");
        send(8'h11, 1'b0, "bw_d2");
        i2c_stop();
        chk("bw_nstb", sa.size(), 3);
        chk("bw_a0", sa[0], 8'h98);
        chk("bw_a1", sa[1], 8'h99);
        chk("bw_a2", sa[2], 8'h9A);
        chk("bw_d2v", sd[2], 8'h11);
        i2c_start();
        send(8'h73, 1'b0, "bw_rd_dev");
        recv(1'b1, 8'h5A, "bw_ptr9b");
        i2c_stop();

        // combined read of 0xD6/0xD7
        i2c_start();
        send(8'h72, 1'b0, "cr_wdev");
        send(8'hD6, 1'b0, "cr_wreg");
        send(8'hC0, 1'b0, "cr_wd0");
        send(8'hE5, 1'b0, "cr_wd1");
        i2c_stop();
        i2c_start();
        send(8'h72, 1'b0, "cr_dev");
        send(8'hD6, 1'b0, "cr_reg");
        i2c_start();
        send(8'h73, 1'b0, "cr_rdev");
        recv(1'b0, 8'hC0, "cr_byte0");
        recv(1'b1, 8'hE5, "cr_byte1");
        chk("cr_oe_rel", sda_oe, 0);
        chk("cr_busy", busy, 1);
        i2c_stop();
        chk("cr_busy_off", busy, 0);

        // address mismatch
        sa.delete(); sd.delete(); oe_seen = 1'b0;
        i2c_start();
        send(8'h70, 1'b1, "mm_nack");
        send(8'h41, 1'b1, "mm_reg");
        send(8'h55, 1'b1, "mm_dat");
        i2c_stop();
        chk("mm_oe", oe_seen, 0);
        chk("mm_nstb", sa.size(), 0);
        chk("mm_busy", busy, 0);
        hread(8'h41, 8'h10, "mm_keep");

        // pointer wrap
        sa.delete(); sd.delete();
        i2c_start();
        send(8'h72, 1'b0, "wr_dev");
        send(8'hFF, 1'b0, "wr_reg");
        send(8'hAA, 1'b0, "wr_d0");
        send(8'hBB, 1'b0, "wr_d1");
        i2c_stop();
        chk("wr_nstb", sa.size(), 2);
        chk("wr_a0", sa[0], 8'hFF);
        chk("wr_a1", sa[1], 8'h00);
        hread(8'h00, 8'hBB, "wr_host0");
        hread(8'hFF, 8'hAA, "wr_hostff");

        // pointer-only write then read
        i2c_start();
        send(8'h72, 1'b0, "po_sdev");
        send(8'h20, 1'b0, "po_sreg");
        send(8'h77, 1'b0, "po_sdat");
        i2c_stop();
        sa.delete(); sd.delete();
        i2c_start();
        send(8'h72, 1'b0, "po_dev");
        send(8'h20, 1'b0, "po_reg");
        i2c_stop();
        chk("po_nstb", sa.size(), 0);
        i2c_start();
        send(8'h73, 1'b0, "po_rdev");
        recv(1'b1, 8'h77, "po_read");
        i2c_stop();

        // reset while ACKing the address
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a72;
            a72 = 8'h72;
            clk_bit(a72[i], r);
        end
        sda_m = 1'b1;
        wq(Q);
        chk("ra_oe_on", sda_oe, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ra_oe_off", sda_oe, 0);
        chk("ra_busy", busy, 0);
        reset = 1'b0;
        oe_seen = 1'b0; sa.delete(); sd.delete();
        wq(Q);
        scl = 1'b1; wq(2 * Q);
        scl = 1'b0; wq(Q);
        send(8'h41, 1'b1, "ra_ignored");
        i2c_stop();
        chk("ra_no_oe", oe_seen, 0);
        chk("ra_nstb0", sa.size(), 0);
        i2c_start();
        send(8'h72, 1'b0, "ra_dev");
        send(8'h30, 1'b0, "ra_reg");
        send(8'h66, 1'b0, "ra_dat");
        i2c_stop();
        chk("ra_nstb", sa.size(), 1);
        chk("ra_waddr", sa[0], 8'h30);
        hread(8'h30, 8'h66, "ra_host");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/i2c_reg_target.md
Name: i2c_reg_target

Overview:
- I2C target (responder) with an internal 8-bit register file.
- Emulates the ADV7513 register interface so the adv7513_init and adv7513_reg_read masters can be exercised in simulation and on-board loopback without the real part.
- Sits on the same open-drain I2C_SCL/I2C_SDA bus as the masters; the top level ties SDA low when sda_oe=1.
- Host-side ports expose written registers and allow backdoor reads.

Parameters:
- DEV_ADDR, 7'h39, 7-bit target address (ADV7513 8-bit address 0x72).
- REG_AW, 8, register address width; register file depth is 2**REG_AW.
- SDA_HOLD, 4, clk cycles between the detected SCL falling edge and any change of sda_oe.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL from the pad, asynchronous.
- sda_in  in  1  raw SDA from the pad, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- wr_strobe  out  1  one-cycle pulse per register byte written over I2C.
- wr_addr  out  REG_AW  register address of the write.
- wr_data  out  8  data of the write.
- host_addr  in  REG_AW  backdoor read address.
- host_data  out  8  registered backdoor read data, 1-cycle latency.
- busy  out  1  high from a START matching DEV_ADDR until STOP.

Behaviour:
- Input sync: scl_in and sda_in each pass through 2-FF synchronizers.
- Edge detect: a third register stage on the synchronized signals gives scl_rise, scl_fall, sda_rise, sda_fall.
- START = sda_fall while synced SCL is high. STOP = sda_rise while synced SCL is high. Both take priority over any data-bit event in the same cycle.
- Bit timing: bits are sampled on scl_rise, MSB first. sda_oe changes only SDA_HOLD cycles after scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7-bit address + R/W).
  - ADDR_ACK: address match → drive ACK. Mismatch → sda_oe stays 0, go to IGNORE.
  - REG: shift register pointer.
  - REG_ACK: drive ACK, go to WDATA.
  - WDATA: shift data byte.
  - WDATA_ACK: write regfile[ptr], pulse wr_strobe, ptr += 1, drive ACK, go to WDATA.
  - RDATA: load the shift register from regfile[ptr] at entry, drive bits, ptr += 1 after the 8th bit.
  - RDATA_ACK: sample the master's ACK. ACK (0) → RDATA. NACK (1) → IGNORE.
  - IGNORE: wait for START or STOP; never drives SDA.
- Read after ADDR_ACK with R/W=1 goes to RDATA starting at the current ptr.
- Any START (including a repeated start) → ADDR. Any STOP → IDLE. In both cases sda_oe is released within 1 cycle.
- Release timing: ACK is held from the SDA_HOLD point after the 8th scl_fall until the SDA_HOLD point after the 9th scl_fall, then sda_oe=0. Read data is likewise released after the 8th bit so the master can drive its ACK.
- ptr wraps from 2**REG_AW-1 to 0. ptr persists across transactions (read without a pointer write uses the last ptr).
- Write with a pointer byte only (STOP right after REG_ACK) sets ptr and writes nothing.
- Reset:
  - Clears state to IDLE, sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, host_data=0, busy=0, ptr=0, shift counters.
  - Regfile contents are NOT reset (RAM-inferable).
  - Reset mid-transaction releases SDA on the next clk edge. The bus is then ignored until the next START.
- host read and I2C write to the same address in the same cycle: host_data returns the old value.

Decomposition:
- Shared package i2c_pkg holds:
  - state encoding localparams;
  - ADV7513_ADDR_7B = 7'h39;
  - ACK/NACK bit constants;
  - I2C_CLKDIV default used by the masters, so benches agree on SCL rate.
- One sub-module, i2c_sync_edge: 2-FF synchronizer + edge/START/STOP detector, reusable by future camera I2C (SCCB) blocks.

Test Plan:
- Single write: START, 0x72, 0x41, 0x10, STOP.
  → ACK on all three bytes; one wr_strobe with wr_addr=0x41, wr_data=0x10; host_addr=0x41 gives host_data=0x10 next cycle.
- Burst write: 0x72, 0x98, 0x03, 0x02, 0x11.
  → strobes at 0x98/0x99/0x9A; ptr ends at 0x9B.
- Combined read after writing 0xD6=0xC0: START, 0x72, 0xD6, Sr, 0x73, read 2 bytes, ACK then NACK, STOP.
  → bytes 0xC0 then regfile[0xD7]; SDA released after the NACK; busy falls on STOP.
- Address mismatch: START, 0x70, 0x41, 0x55, STOP.
  → sda_oe never asserts; no wr_strobe; regfile[0x41] unchanged.
- Wrap and pointer-only: write ptr 0xFF with data 0xAA, 0xBB.
  → writes to 0xFF then 0x00.
  - A following pointer-only write to 0x20 produces no strobe; the next read returns regfile[0x20].
- Reset mid-ACK: assert reset while sda_oe=1 during ADDR_ACK.
  → sda_oe=0 next cycle, busy=0; subsequent bits ignored until a new START; the next full write succeeds.
